// File: rtl/memo_readback.sv
// memo_readback: drains the MC_B result memory word by word onto a valid/ready stream.
// Defining MEMO_READBACK_CHECKSUM_EN appends a modulo-2^DATA_W checksum word to each pass.
module memo_readback #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2,
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              Reset,
    input  logic              Start,
    output logic              RdEnB,
    output logic [ADDR_W-1:0] RdAddrB,
    input  logic [DATA_W-1:0] DataOutB,
    output logic [DATA_W-1:0] DOut,
    output logic              DValid,
    input  logic              DReady,
    output logic              Busy,
    output logic              Done
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        CAPTURE = 3'd2,
        HOLD    = 3'd3,
        FINISH  = 3'd4
`ifdef MEMO_READBACK_CHECKSUM_EN
        , CHECK = 3'd5
`endif
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    state_t            state_reg;
    logic [ADDR_W-1:0] idx_reg;
    logic              handshake;
    logic              last_word;

`ifdef MEMO_READBACK_CHECKSUM_EN
    logic [DATA_W-1:0] acc_reg;
`endif

    // DReady only matters while a word is actually on the stream.
    assign handshake = DValid && DReady;
    assign last_word = (idx_reg == LAST_IDX);

    always_ff @(posedge clock) begin
        if (Reset) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            RdEnB     <= 1'b0;
            RdAddrB   <= '0;
            DOut      <= '0;
            DValid    <= 1'b0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
`ifdef MEMO_READBACK_CHECKSUM_EN
            acc_reg   <= '0;
`endif
        end else begin
            Done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (Start) begin
                        RdEnB     <= 1'b1;
                        RdAddrB   <= '0;
                        idx_reg   <= '0;
                        Busy      <= 1'b1;
`ifdef MEMO_READBACK_CHECKSUM_EN
                        acc_reg   <= '0;
`endif
                        state_reg <= FETCH;
                    end
                end

                // Read data appears one cycle after the strobe, so this state just drops it.
                FETCH: begin
                    RdEnB     <= 1'b0;
                    state_reg <= CAPTURE;
                end

                CAPTURE: begin
                    DOut      <= DataOutB;
                    DValid    <= 1'b1;
`ifdef MEMO_READBACK_CHECKSUM_EN
                    acc_reg   <= acc_reg + DataOutB;
`endif
                    state_reg <= HOLD;
                end

                HOLD: begin
                    if (handshake) begin
                        if (!last_word) begin
                            DValid    <= 1'b0;
                            idx_reg   <= idx_reg + 1'b1;
                            RdEnB     <= 1'b1;
                            RdAddrB   <= idx_reg + 1'b1;
                            state_reg <= FETCH;
                        end else begin
`ifdef MEMO_READBACK_CHECKSUM_EN
                            // Checksum goes out on the very next cycle; the accumulator
                            // already holds the last word added in CAPTURE.
                            DOut      <= acc_reg;
                            DValid    <= 1'b1;
                            state_reg <= CHECK;
`else
                            DValid    <= 1'b0;
                            Done      <= 1'b1;
                            state_reg <= FINISH;
`endif
                        end
                    end
                end

`ifdef MEMO_READBACK_CHECKSUM_EN
                CHECK: begin
                    if (handshake) begin
                        DValid    <= 1'b0;
                        Done      <= 1'b1;
                        state_reg <= FINISH;
                    end
                end
`endif

                // Done is visible during this state; Start here is deliberately dropped.
                FINISH: begin
                    Busy      <= 1'b0;
                    idx_reg   <= '0;
                    RdAddrB   <= '0;
                    state_reg <= IDLE;
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memo_readback.sv
// tb_memo_readback: directed stimulus with queued expectations; a negedge monitor checks them.
module tb_memo_readback;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;
    localparam int DATA_W = 8;
`ifdef MEMO_READBACK_CHECKSUM_EN
    localparam bit CS = 1'b1;
`else
    localparam bit CS = 1'b0;
`endif

    logic              clock  = 1'b0;
    logic              Reset  = 1'b1;
    logic              Start  = 1'b0;
    logic              DReady = 1'b0;
    logic              RdEnB;
    logic [ADDR_W-1:0] RdAddrB;
    logic [DATA_W-1:0] DataOutB = '0;
    logic [DATA_W-1:0] DOut;
    logic              DValid;
    logic              Busy;
    logic              Done;

    logic [DATA_W-1:0] mem [DEPTH];
    int cyc = 0;
    int checks = 0;
    int failures = 0;

    typedef struct {
        int val;
        int cyc;
    } exp_t;

    exp_t hs_q[$];
    exp_t addr_q[$];
    int   done_q[$];

    logic expect_rst  = 1'b0;
    logic expect_idle = 1'b0;
    logic end_req     = 1'b0;

    memo_readback #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clock    (clock),
        .Reset    (Reset),
        .Start    (Start),
        .RdEnB    (RdEnB),
        .RdAddrB  (RdAddrB),
        .DataOutB (DataOutB),
        .DOut     (DOut),
        .DValid   (DValid),
        .DReady   (DReady),
        .Busy     (Busy),
        .Done     (Done)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // MC_B model: data valid exactly one cycle after the strobe, junk otherwise.
    always @(posedge clock) DataOutB <= (RdEnB === 1'b1) ? mem[RdAddrB] : 8'hEE;

    // Monitor
    logic             prev_hold = 1'b0;
    logic [DATA_W-1:0] prev_dout = '0;
    int               last_done = -10;
    logic             fin_done  = 1'b0;

    always @(negedge clock) begin
        exp_t e;
        if (expect_rst) begin
            checks++;
            if ({RdEnB, RdAddrB, DOut, DValid, Busy, Done} !== '0) begin
                failures++;
                $display("FAIL reset_state cyc=%0d got rden=%b addr=%0d dout=%h dvalid=%b busy=%b done=%b, required all zero",
                         cyc, RdEnB, RdAddrB, DOut, DValid, Busy, Done);
            end
        end
        if (expect_idle) begin
            checks++;
            if ({RdEnB, DValid, Busy, Done} !== 4'b0000) begin
                failures++;
                $display("FAIL idle_state cyc=%0d got rden=%b dvalid=%b busy=%b done=%b, required 0 0 0 0",
                         cyc, RdEnB, DValid, Busy, Done);
            end
        end
        if (prev_hold) begin
            checks++;
            if (DValid !== 1'b1 || DOut !== prev_dout || RdEnB !== 1'b0) begin
                failures++;
                $display("FAIL hold_stable cyc=%0d got dvalid=%b dout=%h rden=%b, required 1 %h 0",
                         cyc, DValid, DOut, RdEnB, prev_dout);
            end
        end

        if (addr_q.size() > 0 && addr_q[0].cyc < cyc) begin
            e = addr_q.pop_front();
            checks++;
            failures++;
            $display("FAIL rd_missing cyc=%0d got no strobe, required addr %0d at cyc %0d", cyc, e.val, e.cyc);
        end
        if (RdEnB === 1'b1) begin
            checks++;
            if (addr_q.size() == 0) begin
                failures++;
                $display("FAIL rd_unexpected cyc=%0d got strobe addr=%0d, required none", cyc, RdAddrB);
            end else begin
                e = addr_q.pop_front();
                if (RdAddrB !== ADDR_W'(e.val) || cyc != e.cyc) begin
                    failures++;
                    $display("FAIL rd_addr got addr=%0d cyc=%0d, required addr=%0d cyc=%0d", RdAddrB, cyc, e.val, e.cyc);
                end
            end
        end

        if (hs_q.size() > 0 && hs_q[0].cyc < cyc) begin
            e = hs_q.pop_front();
            checks++;
            failures++;
            $display("FAIL word_missing cyc=%0d got no handshake, required %h at cyc %0d", cyc, e.val, e.cyc);
        end
        if (DValid === 1'b1 && DReady === 1'b1 && Reset === 1'b0) begin
            checks++;
            if (hs_q.size() == 0) begin
                failures++;
                $display("FAIL word_unexpected cyc=%0d got dout=%h, required no word", cyc, DOut);
            end else begin
                e = hs_q.pop_front();
                $display("word cyc=%0d dout=%h", cyc, DOut);
                if (DOut !== DATA_W'(e.val) || cyc != e.cyc) begin
                    failures++;
                    $display("FAIL word got dout=%h cyc=%0d, required dout=%h cyc=%0d", DOut, cyc, e.val, e.cyc);
                end
            end
        end

        if (done_q.size() > 0 && done_q[0] < cyc) begin
            checks++;
            failures++;
            $display("FAIL done_missing cyc=%0d got no pulse, required at cyc %0d", cyc, done_q.pop_front());
        end
        if (Done === 1'b1) begin
            checks++;
            if (done_q.size() == 0 || done_q[0] != cyc || Busy !== 1'b1) begin
                failures++;
                $display("FAIL done got pulse at cyc=%0d busy=%b, required pulse at cyc %0d busy=1",
                         cyc, Busy, (done_q.size() > 0) ? done_q[0] : -1);
            end
            if (done_q.size() > 0 && done_q[0] == cyc) void'(done_q.pop_front());
            last_done = cyc;
        end
        if (cyc == last_done + 1) begin
            checks++;
            if (Busy !== 1'b0) begin
                failures++;
                $display("FAIL busy_drop cyc=%0d got busy=%b, required 0", cyc, Busy);
            end
        end

        if (end_req && !fin_done) begin
            checks++;
            if (hs_q.size() != 0 || addr_q.size() != 0 || done_q.size() != 0) begin
                failures++;
                $display("FAIL leftover got words=%0d reads=%0d dones=%0d pending, required 0 0 0",
                         hs_q.size(), addr_q.size(), done_q.size());
            end
            fin_done = 1'b1;
        end

        prev_hold = (DValid === 1'b1 && DReady === 1'b0 && Reset === 1'b0);
        prev_dout = DOut;
    end

    // Stimulus
    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic push_word(input int v, input int c);
        exp_t e;
        e.val = v;
        e.cyc = c;
        hs_q.push_back(e);
    endtask

    task automatic push_addr(input int a, input int c);
        exp_t e;
        e.val = a;
        e.cyc = c;
        addr_q.push_back(e);
    endtask

    // Start at cycle t: strobe at t+1, word at t+3, then 3 cycles per word with DReady high.
    // stall adds extra hold cycles on the second word.
    task automatic plan_pass(input int t, input int stall,
                             input int w0, input int w1, input int w2, input int w3,
                             input int csum, output int done_cyc);
        int h;
        push_addr(0, t + 1);
        h = t + 3;
        push_word(w0, h);
        push_addr(1, h + 1);
        h = h + 3 + stall;
        push_word(w1, h);
        push_addr(2, h + 1);
        h = h + 3;
        push_word(w2, h);
        push_addr(3, h + 1);
        h = h + 3;
        push_word(w3, h);
        if (CS) begin
            h = h + 1;
            push_word(csum, h);
        end
        done_cyc = h + 1;
        done_q.push_back(done_cyc);
    endtask

    task automatic load_mem(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
        mem[0] = a;
        mem[1] = b;
        mem[2] = c;
        mem[3] = d;
    endtask

    initial begin
        int t;
        int dc;
        load_mem(8'h00, 8'h00, 8'h00, 8'h00);

        tick(3);
        Reset = 1'b0;
        expect_rst = 1'b1;
        tick(5);
        expect_rst = 1'b0;

        // Full pass, DReady held high
        load_mem(8'h03, 8'h07, 8'h0B, 8'h0F);
        DReady = 1'b1;
        t = cyc;
        plan_pass(t, 0, 'h03, 'h07, 'h0B, 'h0F, 'h24, dc);
        Start = 1'b1;
        tick(1);
        Start = 1'b0;
        tick(dc - cyc + 2);
        expect_idle = 1'b1;
        tick(3);
        expect_idle = 1'b0;

        // Consumer stalls on the second word for 4 cycles
        t = cyc;
        plan_pass(t, 4, 'h03, 'h07, 'h0B, 'h0F, 'h24, dc);
        Start = 1'b1;
        tick(1);
        Start = 1'b0;
        tick(3);
        DReady = 1'b0;
        tick(6);
        DReady = 1'b1;
        tick(dc - cyc + 2);
        expect_idle = 1'b1;
        tick(2);
        expect_idle = 1'b0;

        // Wrapping checksum, with Start re-pulsed in HOLD and in FINISH
        load_mem(8'hFF, 8'hFF, 8'h02, 8'h00);
        t = cyc;
        plan_pass(t, 0, 'hFF, 'hFF, 'h02, 'h00, 'h00, dc);
        Start = 1'b1;
        tick(1);
        Start = 1'b0;
        tick(2);
        Start = 1'b1;
        tick(1);
        Start = 1'b0;
        tick(2);
        Start = 1'b1;
        tick(1);
        Start = 1'b0;
        tick(dc - cyc);
        Start = 1'b1;
        tick(1);
        Start = 1'b0;
        tick(3);
        expect_idle = 1'b1;
        tick(4);
        expect_idle = 1'b0;

        // Reset while holding word 1: pass abandoned, no Done
        load_mem(8'h03, 8'h07, 8'h0B, 8'h0F);
        t = cyc;
        push_addr(0, t + 1);
        push_word('h03, t + 3);
        push_addr(1, t + 4);
        Start = 1'b1;
        tick(1);
        Start = 1'b0;
        tick(3);
        DReady = 1'b0;
        tick(3);
        Reset = 1'b1;
        tick(1);
        Reset = 1'b0;
        expect_rst = 1'b1;
        tick(3);
        expect_rst = 1'b0;

        // Clean pass after the abandoned one
        DReady = 1'b1;
        t = cyc;
        plan_pass(t, 0, 'h03, 'h07, 'h0B, 'h0F, 'h24, dc);
        Start = 1'b1;
        tick(1);
        Start = 1'b0;
        tick(dc - cyc + 2);
        expect_idle = 1'b1;
        tick(3);
        expect_idle = 1'b0;

        end_req = 1'b1;
        tick(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
